// File: rtl/pkt_sink_pkg.sv
// Shared types and helpers for the packet sink checker.
//   state_e       : stream lock state (S_IDLE before the first packet, S_RUN after)
//   ID_WIDTH      : width of the sequence ID carried in the top payload bits
//   in_fwd_window : true when an ID difference counts as a forward gap
package pkt_sink_pkg;

  localparam int unsigned ID_WIDTH = 32;

  typedef enum logic [0:0] {
    S_IDLE,
    S_RUN
  } state_e;

  // diff = id - expected, modulo 2^32. Values below 2^31 count as forward
  // gaps; the upper half means a duplicate or backward ID.
  function automatic logic in_fwd_window(input logic [ID_WIDTH-1:0] diff);
    return ~diff[ID_WIDTH-1];
  endfunction

endpackage

// File: rtl/ready_gen.sv
// Backpressure pattern generator.
// A free-running phase counter walks 0..READY_PERIOD-1; ready is low for the
// last STALL_CYCLES phases of every period and high otherwise.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset (phase 0, ready low)
//   ready : registered ready, reflects the phase of the previous cycle
module ready_gen #(
  parameter int unsigned READY_PERIOD = 8,
  parameter int unsigned STALL_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  output logic ready
);

  localparam int unsigned PhaseWidth  = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
  localparam int unsigned ReadyPhases = READY_PERIOD - STALL_CYCLES;
  localparam logic [PhaseWidth-1:0] LastPhase = PhaseWidth'(READY_PERIOD - 1);

  logic [PhaseWidth-1:0] phase_q, phase_d;
  logic                  ready_q, ready_d;

  always_comb begin
    phase_d = (phase_q == LastPhase) ? '0 : phase_q + 1'b1;
    ready_d = (32'(phase_q) < ReadyPhases);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      ready_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;

endmodule

// File: rtl/pkt_sink_checker.sv
// Packet sink and stream checker terminating one NoC egress port.
// Accepts packets under a programmable backpressure pattern, checks the
// sequence ID in the top 32 payload bits and the destination field, and keeps
// receive / drop / error counters.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   pkt_data_in      : payload, ID in bits [DATA_WIDTH-1 -: 32]
//   pkt_dest_in      : destination field, expected to equal MY_DEST
//   pkt_valid_in     : packet present
//   pkt_ready_out    : sink accepts this cycle
//   rx_count         : accepted packets (wraps)
//   drop_count       : IDs skipped by forward gaps (wraps)
//   seq_err_count    : duplicate/backward IDs (saturates)
//   dest_err_count   : destination mismatches (saturates)
//   last_id          : ID of the most recent accepted packet
//   err_out          : sticky error flag
module pkt_sink_checker
  import pkt_sink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 500,
  parameter int unsigned DEST_WIDTH   = 4,
  parameter int unsigned MY_DEST      = 1,
  parameter int unsigned READY_PERIOD = 8,
  parameter int unsigned STALL_CYCLES = 0,
  parameter int unsigned ERR_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pkt_data_in,
  input  logic [DEST_WIDTH-1:0] pkt_dest_in,
  input  logic                  pkt_valid_in,
  output logic                  pkt_ready_out,
  output logic [31:0]           rx_count,
  output logic [31:0]           drop_count,
  output logic [ERR_WIDTH-1:0]  seq_err_count,
  output logic [ERR_WIDTH-1:0]  dest_err_count,
  output logic [31:0]           last_id,
  output logic                  err_out
);

  logic                ready;
  logic                accept;
  logic [ID_WIDTH-1:0] id;
  logic [ID_WIDTH-1:0] diff;
  logic                dest_bad;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] expected_q, expected_d;
  logic [31:0]         rx_q, rx_d;
  logic [31:0]         drop_q, drop_d;
  logic [ERR_WIDTH-1:0] seq_err_q, seq_err_d;
  logic [ERR_WIDTH-1:0] dest_err_q, dest_err_d;
  logic [ID_WIDTH-1:0] last_id_q, last_id_d;
  logic                err_q, err_d;

  ready_gen #(
    .READY_PERIOD (READY_PERIOD),
    .STALL_CYCLES (STALL_CYCLES)
  ) u_ready_gen (
    .clk   (clk),
    .reset (reset),
    .ready (ready)
  );

  // Only the ID field of the payload is inspected.
  if (DATA_WIDTH > ID_WIDTH) begin : g_unused_payload
    logic unused_payload;
    assign unused_payload = ^pkt_data_in[DATA_WIDTH-ID_WIDTH-1:0];
  end

  assign accept   = pkt_valid_in && ready;
  assign id       = pkt_data_in[DATA_WIDTH-1 -: ID_WIDTH];
  assign diff     = id - expected_q;
  assign dest_bad = (pkt_dest_in != DEST_WIDTH'(MY_DEST));

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    rx_d       = rx_q;
    drop_d     = drop_q;
    seq_err_d  = seq_err_q;
    dest_err_d = dest_err_q;
    last_id_d  = last_id_q;
    err_d      = err_q;

    if (accept) begin
      rx_d       = rx_q + 32'd1;
      last_id_d  = id;
      // Always resync to the received ID so one glitch reports one error.
      expected_d = id + 32'd1;
      state_d    = S_RUN;

      // The first packet after reset only locks the stream.
      if (state_q == S_RUN && diff != '0) begin
        err_d = 1'b1;
        if (in_fwd_window(diff)) begin
          drop_d = drop_q + diff;
        end else if (seq_err_q != '1) begin
          seq_err_d = seq_err_q + 1'b1;
        end
      end

      if (dest_bad) begin
        err_d = 1'b1;
        if (dest_err_q != '1) begin
          dest_err_d = dest_err_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      expected_q <= '0;
      rx_q       <= '0;
      drop_q     <= '0;
      seq_err_q  <= '0;
      dest_err_q <= '0;
      last_id_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      rx_q       <= rx_d;
      drop_q     <= drop_d;
      seq_err_q  <= seq_err_d;
      dest_err_q <= dest_err_d;
      last_id_q  <= last_id_d;
      err_q      <= err_d;
    end
  end

  assign pkt_ready_out  = ready;
  assign rx_count       = rx_q;
  assign drop_count     = drop_q;
  assign seq_err_count  = seq_err_q;
  assign dest_err_count = dest_err_q;
  assign last_id        = last_id_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_pkt_sink_checker.sv
// Self-checking bench for pkt_sink_checker: directed scenarios plus a
// randomized stream compared against a reference model of the ID rules.
module tb_pkt_sink_checker;

  localparam int unsigned DW    = 500;
  localparam int unsigned DESTW = 4;
  localparam int unsigned EW    = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             valid = 1'b0;
  logic [DW-1:0]    data = '0;
  logic [DESTW-1:0] dest = '0;

  logic             pkt_ready_out, err_out;
  logic [31:0]      rx_count, drop_count, last_id;
  logic [EW-1:0]    seq_err_count, dest_err_count;

  logic             bp_ready, bp_err;
  logic [31:0]      bp_rx, bp_drop, bp_last;
  logic [EW-1:0]    bp_seq, bp_dest;

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit          m_locked;
  logic [31:0] m_prev, m_rx, m_drop, m_last;
  logic [EW-1:0] m_seq, m_dest;
  bit          m_err;

  always #5 clk = ~clk;

  pkt_sink_checker #(
    .DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .MY_DEST(1),
    .READY_PERIOD(8), .STALL_CYCLES(0), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .reset(reset), .pkt_data_in(data), .pkt_dest_in(dest),
    .pkt_valid_in(valid), .pkt_ready_out(pkt_ready_out), .rx_count(rx_count),
    .drop_count(drop_count), .seq_err_count(seq_err_count),
    .dest_err_count(dest_err_count), .last_id(last_id), .err_out(err_out)
  );

  pkt_sink_checker #(
    .DATA_WIDTH(DW), .DEST_WIDTH(DESTW), .MY_DEST(1),
    .READY_PERIOD(4), .STALL_CYCLES(1), .ERR_WIDTH(EW)
  ) dut_bp (
    .clk(clk), .reset(reset), .pkt_data_in(data), .pkt_dest_in(dest),
    .pkt_valid_in(valid), .pkt_ready_out(bp_ready), .rx_count(bp_rx),
    .drop_count(bp_drop), .seq_err_count(bp_seq),
    .dest_err_count(bp_dest), .last_id(bp_last), .err_out(bp_err)
  );

  task automatic model_reset();
    m_locked = 0; m_prev = '0; m_rx = '0; m_drop = '0; m_last = '0;
    m_seq = '0; m_dest = '0; m_err = 0;
  endtask

  // Each accepted packet should directly follow the previous one; a forward
  // gap counts the skipped IDs, anything in the backward half is a sequence error.
  task automatic model_accept(input logic [31:0] id, input logic [DESTW-1:0] d);
    logic [31:0] gap;
    if (m_locked) begin
      gap = id - m_prev - 32'd1;
      if (gap != 32'd0) begin
        m_err = 1;
        if (gap < 32'h8000_0000) m_drop = m_drop + gap;
        else if (m_seq != '1) m_seq = m_seq + 1'b1;
      end
    end
    if (d != DESTW'(1)) begin
      m_err = 1;
      if (m_dest != '1) m_dest = m_dest + 1'b1;
    end
    m_locked = 1; m_prev = id; m_last = id; m_rx = m_rx + 32'd1;
  endtask

  task automatic fill_data(input logic [31:0] id);
    for (int i = 0; i < DW; i++) data[i] = 1'($urandom_range(0, 1));
    data[DW-1 -: 32] = id;
  endtask

  // Called at a negedge; returns at the following negedge with valid low.
  task automatic send_pkt(input logic [31:0] id, input logic [DESTW-1:0] d);
    fill_data(id);
    dest = d;
    valid = 1'b1;
    compared++;
    if (pkt_ready_out !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_during_send: got %b want 1 (id %h)", pkt_ready_out, id);
    end
    @(posedge clk);
    model_accept(id, d);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({pkt_ready_out, bp_ready, rx_count, drop_count, seq_err_count, dest_err_count,
         last_id, err_out, bp_rx, bp_err} !== '0) begin
      mismatched++;
      $display("FAIL reset_values: rdy=%b bp_rdy=%b rx=%0d drop=%0d seq=%0d dest=%0d last=%h err=%b",
               pkt_ready_out, bp_ready, rx_count, drop_count, seq_err_count, dest_err_count,
               last_id, err_out);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    compared++;
    if (pkt_ready_out !== 1'b1 || bp_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL ready_after_reset: got %b/%b want 1/1", pkt_ready_out, bp_ready);
    end
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 0; i < 10; i++) send_pkt(32'(i), 4'd1);
    compared++;
    if (rx_count !== 32'd10 || last_id !== 32'd9) begin
      mismatched++;
      $display("FAIL in_order_count: rx=%0d last=%0d want 10/9", rx_count, last_id);
    end
    compared++;
    if ({drop_count, seq_err_count, dest_err_count, err_out} !== '0) begin
      mismatched++;
      $display("FAIL in_order_errors: drop=%0d seq=%0d dest=%0d err=%b want all 0",
               drop_count, seq_err_count, dest_err_count, err_out);
    end
  endtask

  task automatic test_gap();
    do_reset();
    send_pkt(32'd0, 4'd1); send_pkt(32'd1, 4'd1); send_pkt(32'd5, 4'd1);
    compared++;
    if (drop_count !== 32'd3 || seq_err_count !== '0 || err_out !== 1'b1) begin
      mismatched++;
      $display("FAIL gap: drop=%0d seq=%0d err=%b want 3/0/1", drop_count, seq_err_count, err_out);
    end
    send_pkt(32'd6, 4'd1);
    compared++;
    if (drop_count !== 32'd3 || seq_err_count !== '0 || rx_count !== 32'd4) begin
      mismatched++;
      $display("FAIL gap_resync: drop=%0d seq=%0d rx=%0d want 3/0/4",
               drop_count, seq_err_count, rx_count);
    end
  endtask

  task automatic test_duplicate();
    do_reset();
    send_pkt(32'd0, 4'd1); send_pkt(32'd1, 4'd1);
    send_pkt(32'd1, 4'd1); send_pkt(32'd2, 4'd1);
    compared++;
    if (seq_err_count !== 16'd1 || drop_count !== 32'd0 || rx_count !== 32'd4
        || err_out !== 1'b1) begin
      mismatched++;
      $display("FAIL duplicate: seq=%0d drop=%0d rx=%0d err=%b want 1/0/4/1",
               seq_err_count, drop_count, rx_count, err_out);
    end
  endtask

  task automatic test_dest();
    do_reset();
    send_pkt(32'd0, 4'd1); send_pkt(32'd1, 4'd2);
    compared++;
    if (dest_err_count !== 16'd1 || rx_count !== 32'd2 || seq_err_count !== '0
        || drop_count !== '0 || err_out !== 1'b1) begin
      mismatched++;
      $display("FAIL dest: dest=%0d rx=%0d seq=%0d drop=%0d err=%b want 1/2/0/0/1",
               dest_err_count, rx_count, seq_err_count, drop_count, err_out);
    end
  endtask

  task automatic test_drop_and_dest();
    do_reset();
    send_pkt(32'd0, 4'd1); send_pkt(32'd3, 4'd5);
    compared++;
    if (drop_count !== 32'd2 || dest_err_count !== 16'd1 || rx_count !== 32'd2) begin
      mismatched++;
      $display("FAIL drop_and_dest: drop=%0d dest=%0d rx=%0d want 2/1/2",
               drop_count, dest_err_count, rx_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    send_pkt(32'hFFFF_FFFE, 4'd1); send_pkt(32'hFFFF_FFFF, 4'd1); send_pkt(32'h0, 4'd1);
    compared++;
    if ({drop_count, seq_err_count, dest_err_count, err_out} !== '0
        || last_id !== 32'd0 || rx_count !== 32'd3) begin
      mismatched++;
      $display("FAIL wrap: drop=%0d seq=%0d dest=%0d err=%b last=%h rx=%0d want 0/0/0/0/0/3",
               drop_count, seq_err_count, dest_err_count, err_out, last_id, rx_count);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] n_acc;
    bit exp_rdy;
    bit ok;
    do_reset();
    n_acc = 0;
    ok = 1;
    dest = 4'd1;
    // Cycle k after reset release shows the ready bit for phase k mod 4.
    for (int k = 0; k < 48; k++) begin
      fill_data(n_acc);
      valid = (k < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_rdy = ((k % 4) != 3);
      if (bp_ready !== exp_rdy) begin
        ok = 0;
        $display("FAIL bp_ready_pattern: cycle %0d got %b want %b", k, bp_ready, exp_rdy);
      end
      @(posedge clk);
      if (valid && exp_rdy) n_acc++;
      @(negedge clk);
      if (k == 7) begin
        compared++;
        if (bp_rx !== 32'd6) begin
          mismatched++;
          $display("FAIL bp_rx_8_cycles: got %0d want 6", bp_rx);
        end
      end
    end
    valid = 1'b0;
    compared++;
    if (!ok) mismatched++;
    compared++;
    if (bp_rx !== n_acc || bp_err !== 1'b0 || bp_last !== n_acc - 32'd1) begin
      mismatched++;
      $display("FAIL bp_random: rx=%0d err=%b last=%0d want %0d/0/%0d",
               bp_rx, bp_err, bp_last, n_acc, n_acc - 32'd1);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 5; i++) send_pkt(32'(i * 2), 4'd3);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if ({pkt_ready_out, rx_count, drop_count, seq_err_count, dest_err_count,
         last_id, err_out} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_clear: rx=%0d drop=%0d seq=%0d dest=%0d last=%h err=%b",
               rx_count, drop_count, seq_err_count, dest_err_count, last_id, err_out);
    end
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    send_pkt(32'd100, 4'd1);
    compared++;
    if (rx_count !== 32'd1 || last_id !== 32'd100 || err_out !== 1'b0
        || {drop_count, seq_err_count, dest_err_count} !== '0) begin
      mismatched++;
      $display("FAIL mid_reset_relock: rx=%0d last=%0d err=%b drop=%0d seq=%0d dest=%0d",
               rx_count, last_id, err_out, drop_count, seq_err_count, dest_err_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] id;
    int r;
    logic [DESTW-1:0] d;
    do_reset();
    id = $urandom;
    for (int n = 1; n <= 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      id = id + 32'd1;
      else if (r < 80) id = id + 32'($urandom_range(2, 1000));
      else if (r < 90) id = id - 32'($urandom_range(0, 50));
      else             id = $urandom;
      d = ($urandom_range(0, 99) < 85) ? DESTW'(1) : DESTW'($urandom_range(0, 15));
      send_pkt(id, d);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      if (n % 50 == 0) begin
        compared++;
        if (rx_count !== m_rx || drop_count !== m_drop || seq_err_count !== m_seq
            || dest_err_count !== m_dest || last_id !== m_last || err_out !== m_err) begin
          mismatched++;
          $display("FAIL random_%0d: rx=%0d/%0d drop=%0d/%0d seq=%0d/%0d dest=%0d/%0d last=%h/%h err=%b/%b (got/want)",
                   n, rx_count, m_rx, drop_count, m_drop, seq_err_count, m_seq,
                   dest_err_count, m_dest, last_id, m_last, err_out, m_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_gap();
    test_duplicate();
    test_dest();
    test_drop_and_dest();
    test_wrap();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
